iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 35 +++
 rtl/iter_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state type for iter_alu.
// Imported by alu_core and iter_alu.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op >= OP_MULU) && (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ops (add/sub/logic/shift/compare).
// Ports: op, a, b in; y out (0 for iterative/reserved codes).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [SHW-1:0] sh;

  assign sh = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = WIDTH'($signed(a) >>> sh);
      OP_SLL:  y = a << sh;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: simple ops in one cycle, mul/div one bit per cycle.
// Ports: clk, reset, start/op/a/b in; busy, done, result, hi out.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi
);

  state_t state, nstate;

  logic [SHW-1:0]   cnt;
  logic             mul_q, neg_q, neg_r;
  logic [WIDTH-1:0] a_q, opnd, acc_hi, acc_lo;

  logic [WIDTH-1:0] core_y;
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb;

  logic [WIDTH:0]     sum, shf;
  logic               ge;
  logic [WIDTH-1:0]   dif, nh, nl, fres, fhi;
  logic [2*WIDTH-1:0] prod;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (core_y)
  );

  // operand magnitudes; signs are reapplied after the last step
  always_comb begin
    sgn = (op == OP_MUL) || (op == OP_DIV);
    sa  = sgn & a[WIDTH-1];
    sb  = sgn & b[WIDTH-1];
    ma  = sa ? -a : a;
    mb  = sb ? -b : b;
  end

  // one iteration step plus final sign fix-up
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shf = {acc_hi, acc_lo[WIDTH-1]};
    ge  = shf >= {1'b0, opnd};
    dif = shf[WIDTH-1:0] - opnd;
    if (mul_q) begin
      nh = sum[WIDTH:1];
      nl = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nh = ge ? dif : shf[WIDTH-1:0];
      nl = {acc_lo[WIDTH-2:0], ge};
    end
    prod = {nh, nl};
    if (neg_q) prod = -prod;
    fres = prod[WIDTH-1:0];
    fhi  = prod[2*WIDTH-1:WIDTH];
    if (!mul_q) begin
      if (opnd == '0) begin
        fres = '1;
        fhi  = a_q;
      end else begin
        fres = neg_q ? -nl : nl;
        fhi  = neg_r ? -nh : nh;
      end
    end
  end

  always_comb begin
    nstate = state;
    busy   = (state != IDLE);
    done   = 1'b0;
    unique case (state)
      IDLE: if (start) nstate = is_iter(op) ? ITER : DONE;
      ITER: if (cnt == SHW'(WIDTH-1)) nstate = DONE;
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      hi     <= '0;
      mul_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_q    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && start) begin
        if (is_iter(op)) begin
          cnt    <= '0;
          mul_q  <= (op == OP_MUL) || (op == OP_MULU);
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          a_q    <= a;
          opnd   <= mb;
          acc_hi <= '0;
          acc_lo <= ma;
        end else begin
          result <= core_y;
          hi     <= '0;
        end
      end
      if (state == ITER) begin
        acc_hi <= nh;
        acc_lo <= nl;
        cnt    <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH-1)) begin
          result <= fres;
          hi     <= fhi;
        end
      end
    end
  end

endmodule
